ram_sync: RTL and testbench

Parametrised synchronous data RAM, the successor of the microcomputer's 128 x 8 RAM. Width and depth are generalised, and the memory array has no reset so it maps onto block RAM. After reset, a hardware clear sweep zeroes the memory one word per clock. Accesses use a req/ready/ack handshake, and read data is registered.

---
 rtl/ram_sync.sv | 124 ++++++++++++
 tb/tb_ram_sync.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// ram_sync: parametrised synchronous RAM with post-reset zeroing sweep and req/ready/ack access.
// Optional sticky out-of-range flag built only when RAM_ADDR_ERR_EN is defined.
module ram_sync #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_s2,
    input  logic                  req,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [IW-1:0]         mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    always_ff @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_cnt == LAST) begin
            state_next = S_IDLE;
        end
    end

    // ready is masked by reset so no request is seen while reset is held
    always_comb begin
        ready = (state == S_IDLE) && !reset_s2;
        busy  = (state == S_CLEAR);
    end

    always_ff @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign in_range = {1'b0, address} < SIZE;
    assign accept   = req && ready;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_cnt[IW-1:0];
        mem_wd = '0;
        unique case (1'b1)
            busy: begin
                mem_we = !reset_s2;
            end
            accept && write_enable && in_range: begin
                mem_we = 1'b1;
                mem_wa = address[IW-1:0];
                mem_wd = data_in;
            end
            default: begin
            end
        endcase
    end

    // array has no reset so it can map onto block RAM
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            ack      <= 1'b0;
            data_out <= '0;
        end else begin
            ack <= accept;
            if (accept && !write_enable) begin
                data_out <= in_range ? mem[address[IW-1:0]] : '0;
            end
        end
    end

`ifdef RAM_ADDR_ERR_EN
    always_ff @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            addr_err <= 1'b0;
        end else if (accept && !in_range) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: directed bench for ram_sync with a cycle-level reference model.
// Model tracks sweep length, memory contents, ack and read data per accepted request.
module tb_ram_sync;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 128;
`ifdef RAM_ADDR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock        = 1'b0;
    logic          reset_s2     = 1'b0;
    logic          req          = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] address      = '0;
    logic [DW-1:0] data_in      = '0;
    logic          ready;
    logic          ack;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          addr_err;

    int errors = 0;
    int checks = 0;

    ram_sync #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock),
        .reset_s2(reset_s2),
        .req(req),
        .write_enable(write_enable),
        .address(address),
        .data_in(data_in),
        .ready(ready),
        .ack(ack),
        .data_out(data_out),
        .busy(busy),
        .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model
    logic [DW-1:0] mm [DEPTH];
    int            sweep_left = 0;
    logic          m_ack      = 1'b0;
    logic [DW-1:0] m_data     = '0;
    logic          m_err      = 1'b0;
    bit            armed      = 1'b0;

    always @(posedge clock or posedge reset_s2) begin
        if (reset_s2) begin
            armed      = 1'b1;
            sweep_left = DEPTH;
            m_ack      = 1'b0;
            m_data     = '0;
            m_err      = 1'b0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            m_ack = 1'b0;
            if (sweep_left == 0) begin
                foreach (mm[i]) mm[i] = '0;
            end
        end else begin
            m_ack = req;
            if (req) begin
                if (int'(address) < DEPTH) begin
                    if (write_enable) mm[address[6:0]] = data_in;
                    else m_data = mm[address[6:0]];
                end else begin
                    if (!write_enable) m_data = '0;
                    if (ERR_EN) m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("ready", ready, !reset_s2 && sweep_left == 0);
            chk("busy", busy, sweep_left > 0);
            chk("ack", ack, m_ack);
            chk("data_out", data_out, m_data);
            chk("addr_err", addr_err, m_err);
        end
    end

    task automatic drive(input bit r, input bit we, input int a, input int d);
        req          = r;
        write_enable = we;
        address      = a[AW-1:0];
        data_in      = d[DW-1:0];
    endtask

    task automatic access(input bit we, input int a, input int d);
        drive(1'b1, we, a, d);
        @(posedge clock);
        #2 req = 1'b0;
    endtask

    task automatic wait_sweep(output int n, output bit saw_ack);
        n       = 0;
        saw_ack = 1'b0;
        while (busy && n < 400) begin
            @(posedge clock);
            #3;
            if (ack) saw_ack = 1'b1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int n;
        int nz;
        bit sa;

        // 1: sweep with a write request held throughout
        #1 reset_s2 = 1'b1;
        drive(1'b1, 1'b1, 'h05, 'hAA);
        @(posedge clock);
        @(posedge clock);
        #2 reset_s2 = 1'b0;
        wait_sweep(n, sa);
        req = 1'b0;
        chk("t1_sweep_len", n, 128);
        chk("t1_no_ack", sa, 0);
        chk("t1_ready", ready, 1);
        access(1'b0, 'h05, 0);
        chk("t1_ack", ack, 1);
        chk("t1_read05", data_out, 'h00);

        // 2: write then read
        access(1'b1, 'h10, 'h3C);
        chk("t2_wr_ack", ack, 1);
        access(1'b0, 'h10, 0);
        chk("t2_rd_ack", ack, 1);
        chk("t2_rd_data", data_out, 'h3C);

        // 3: preload then back-to-back reads
        access(1'b1, 'h00, 'h11);
        access(1'b1, 'h7F, 'h22);
        access(1'b1, 'h40, 'h33);
        drive(1'b1, 1'b0, 'h00, 0);
        @(posedge clock); #2;
        chk("t3_ack0", ack, 1);
        chk("t3_data0", data_out, 'h11);
        address = 8'h7F;
        @(posedge clock); #2;
        chk("t3_ack1", ack, 1);
        chk("t3_data1", data_out, 'h22);
        address = 8'h40;
        @(posedge clock); #2;
        chk("t3_ack2", ack, 1);
        chk("t3_data2", data_out, 'h33);
        req = 1'b0;

        // 4: out-of-range write and read
        access(1'b1, 'h80, 'hFF);
        chk("t4_wr_ack", ack, 1);
        chk("t4_err_wr", addr_err, ERR_EN);
        access(1'b0, 'h80, 0);
        chk("t4_rd_ack", ack, 1);
        chk("t4_rd_data", data_out, 'h00);
        access(1'b0, 'h00, 0);
        chk("t4_mem0", data_out, 'h11);
        chk("t4_err_sticky", addr_err, ERR_EN);

        // 6: reset right after a read is accepted
        drive(1'b1, 1'b0, 'h10, 0);
        @(posedge clock);
        #1 reset_s2 = 1'b1;
        #1;
        chk("t6_ack", ack, 0);
        chk("t6_data", data_out, 'h00);
        chk("t6_busy", busy, 1);
        chk("t6_err", addr_err, 0);
        req = 1'b0;
        @(posedge clock);
        #2 reset_s2 = 1'b0;

        // 5: reset mid-sweep, then full sweep and read-back
        repeat (60) @(posedge clock);
        #2 reset_s2 = 1'b1;
        @(posedge clock);
        #2 reset_s2 = 1'b0;
        wait_sweep(n, sa);
        chk("t5_sweep_len", n, 128);
        chk("t5_no_ack", sa, 0);
        nz = 0;
        drive(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clock); #2;
            if (data_out !== 8'h00 || ack !== 1'b1) nz++;
            if (i < DEPTH - 1) address = AW'(i + 1);
            else req = 1'b0;
        end
        chk("t5_all_zero", nz, 0);

        repeat (3) @(posedge clock);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
